// File: rtl/spv_vector_sequencer.sv
// Drives all eight {S,P,V} combinations, samples the LED reply, counts mismatches.
// Optional SPV_FAIL_LOG_EN macro adds first-failure capture ports.
module spv_vector_sequencer #(
    parameter int         HOLD_CYCLES = 100,
    parameter logic [7:0] EXPECT      = 8'hF8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       led_in,
    output logic       s_out,
    output logic       p_out,
    output logic       v_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
`ifdef SPV_FAIL_LOG_EN
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid,
`endif
    output logic [3:0] err_count
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t        state;
    logic [2:0]    vec;
    logic [CW-1:0] cnt;
    logic          smp;
    logic          smp_exp;
    logic [2:0]    smp_vec;
    logic          launch;
    logic          miss;
    logic [3:0]    err_nxt;

    // Outputs lag state by one edge, so the compare is pipelined one
    // cycle to land on the last cycle the vector is actually on the pins.
    assign launch  = start && (state == IDLE || state == DONE);
    assign miss    = smp && (led_in != smp_exp);
    assign err_nxt = launch ? 4'd0 : err_count + {3'd0, miss};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 3'd0;
            cnt       <= '0;
            smp       <= 1'b0;
            smp_exp   <= 1'b0;
            smp_vec   <= 3'd0;
            s_out     <= 1'b0;
            p_out     <= 1'b0;
            v_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
        end else begin
            smp <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= DRIVE;
                        vec   <= 3'd0;
                        cnt   <= '0;
                    end
                end
                DRIVE: begin
                    if (cnt == LAST) begin
                        smp     <= 1'b1;
                        smp_exp <= EXPECT[vec];
                        smp_vec <= vec;
                        cnt     <= '0;
                        if (vec == 3'd7) begin
                            state <= DONE;
                        end else begin
                            vec <= vec + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            busy <= (state == DRIVE);
            {s_out, p_out, v_out} <= (state == DRIVE) ? vec : 3'd0;
            done      <= (state == DONE) && !start;
            pass      <= (state == DONE) && !start && (err_nxt == 4'd0);
            err_count <= err_nxt;
        end
    end

`ifdef SPV_FAIL_LOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else if (launch) begin
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else if (miss && !first_fail_valid) begin
            first_fail_vec   <= smp_vec;
            first_fail_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spv_vector_sequencer.sv
// Bench for spv_vector_sequencer: a response table stands in for the circuit,
// and a table-driven model predicts error count and first failure.
module tb_spv_vector_sequencer;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       led_in;
    logic       s_out, p_out, v_out;
    logic       busy, done, pass;
    logic [3:0] err_count;
`ifdef SPV_FAIL_LOG_EN
    logic [2:0] first_fail_vec;
    logic       first_fail_valid;
`endif

    logic [7:0] resp;
    int         n_cmp = 0;
    int         n_mis = 0;

    always #5 clk = ~clk;

    assign led_in = resp[{s_out, p_out, v_out}];

    spv_vector_sequencer #(.HOLD_CYCLES(H), .EXPECT(8'hF8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .led_in(led_in),
        .s_out(s_out),
        .p_out(p_out),
        .v_out(v_out),
        .busy(busy),
        .done(done),
        .pass(pass),
`ifdef SPV_FAIL_LOG_EN
        .first_fail_vec(first_fail_vec),
        .first_fail_valid(first_fail_valid),
`endif
        .err_count(err_count)
    );

    function automatic logic [7:0] golden();
        logic [7:0] t;
        for (int v = 0; v < 8; v++) begin
            int s, p, q;
            s = (v >> 2) & 1;
            p = (v >> 1) & 1;
            q = v & 1;
            t[v] = ((s | (p & q)) != 0);
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".spv"}, {13'd0, s_out, p_out, v_out}, 16'd0);
        chk({tag, ".busy"}, {15'd0, busy}, 16'd0);
        chk({tag, ".done"}, {15'd0, done}, 16'd0);
        chk({tag, ".pass"}, {15'd0, pass}, 16'd0);
        chk({tag, ".err"}, {12'd0, err_count}, 16'd0);
`ifdef SPV_FAIL_LOG_EN
        chk({tag, ".ffv"}, {15'd0, first_fail_valid}, 16'd0);
        chk({tag, ".ffvec"}, {13'd0, first_fail_vec}, 16'd0);
`endif
    endtask

    // Runs one sequence; pulses=1 adds stray starts, abort_c>0 resets mid-run.
    task automatic run(input string tag, input bit pulses, input int abort_c);
        logic [7:0] g;
        int exp_err;
        int ff;
        g = golden();
        exp_err = 0;
        ff = -1;
        for (int v = 0; v < 8; v++) begin
            if (resp[v] != g[v]) begin
                exp_err++;
                if (ff < 0) ff = v;
            end
        end
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        chk({tag, ".launch_done"}, {15'd0, done}, 16'd0);
        chk({tag, ".launch_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, ".launch_err"}, {12'd0, err_count}, 16'd0);
        for (int c = 1; c <= 8 * H; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (c == abort_c) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                chk_zero({tag, ".abort"});
                return;
            end
            chk({tag, ".busy"}, {15'd0, busy}, 16'd1);
            chk({tag, ".done_low"}, {15'd0, done}, 16'd0);
            chk({tag, ".vec"}, {13'd0, s_out, p_out, v_out}, 16'((c - 1) / H));
            if (pulses && (c == 5 || c == 20)) start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".end_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, ".end_done"}, {15'd0, done}, 16'd1);
        chk({tag, ".end_spv"}, {13'd0, s_out, p_out, v_out}, 16'd0);
        chk({tag, ".err"}, {12'd0, err_count}, 16'(exp_err));
        chk({tag, ".pass"}, {15'd0, pass}, 16'(exp_err == 0));
`ifdef SPV_FAIL_LOG_EN
        chk({tag, ".ffv"}, {15'd0, first_fail_valid}, 16'(ff >= 0));
        if (ff >= 0) chk({tag, ".ffvec"}, {13'd0, first_fail_vec}, 16'(ff));
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, ".hold_done"}, {15'd0, done}, 16'd1);
        chk({tag, ".hold_err"}, {12'd0, err_count}, 16'(exp_err));
    endtask

    initial begin
        resp = golden();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("idle");

        resp = golden();
        run("good", 1'b0, 0);
        resp = 8'h00;
        run("tied0", 1'b0, 0);
        resp = 8'hFF;
        run("tied1", 1'b0, 0);
        resp = golden();
        run("pulses", 1'b1, 0);
        resp = 8'h00;
        run("abort", 1'b0, 4 * H + 2);
        resp = golden();
        run("after_abort", 1'b0, 0);
        resp = 8'h00;
        run("fail_again", 1'b0, 0);
        resp = golden();
        run("restart_done", 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            resp = 8'($urandom_range(0, 255));
            run("random", 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/spv_vector_sequencer.md
# spv_vector_sequencer

Synthesizable stimulus and check engine for the S/P/V → LED combinational circuit. On `start` it drives all eight {S,P,V} input combinations onto the circuit, one at a time. It holds each combination for a programmable number of cycles and samples the returned LED at the end of each hold. Each sample is compared against a parameterized truth table. It acts as the on-chip initiator for the combinational circuit's responder side and reports pass/fail plus an error count.

## Interface
Parameters:
- `HOLD_CYCLES`, default 100: cycles each vector is driven; legal range 2..65535.
- `EXPECT`, default 8'hF8: expected LED per vector. Bit index is {S,P,V}. The default encodes LED = S | (P & V).

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a run. Sampled in IDLE and DONE only.
- `led_in` input 1: LED output of the circuit under test.
- `s_out` output 1: S drive.
- `p_out` output 1: P drive.
- `v_out` output 1: V drive.
- `busy` output 1: high while vectors are being driven.
- `done` output 1: high from run completion until the next start or reset.
- `pass` output 1: valid when `done`=1; it is 1 iff `err_count`==0.
- `err_count` output 4: number of mismatching vectors in the last run, 0..8.
- `first_fail_vec` output 3: present only with SPV_FAIL_LOG_EN; see Configuration.
- `first_fail_valid` output 1: present only with SPV_FAIL_LOG_EN; see Configuration.

## Operation
- State machine states are IDLE, DRIVE and DONE.
- **IDLE**: s/p/v_out=0, busy=0, done=0. When start=1, go to DRIVE with vec=0, hold counter=0 and err_count cleared.
- **DRIVE**: {s_out,p_out,v_out}=vec, busy=1. The hold counter increments each cycle.
  - When counter==HOLD_CYCLES-1, led_in is compared with EXPECT[vec]. A mismatch increments err_count.
  - In that same cycle, if vec<7 then vec advances and the counter resets to 0.
  - If vec==7, the machine goes to DONE instead.
- **DONE**: busy=0, done=1, and s/p/v_out return to 0. pass = (err_count==0).
  - start=1 clears done and err_count and re-enters DRIVE with vec=0.
  - Otherwise the machine stays in DONE indefinitely.
- `start` in DRIVE is ignored; it does not restart or extend the run.
- err_count is 4 bits wide and cannot overflow, since the maximum is 8.
- The hold counter is $clog2(HOLD_CYCLES) bits wide.
- `rst` takes priority over everything and has the same effect in any state, including mid-run:
  - state=IDLE, vec=0, counter=0;
  - all outputs 0, including err_count, done and pass;
  - fail-log outputs 0.

## Timing
- start is sampled high in IDLE at edge N. From edge N+1, busy=1 and vector 0 is driven.
- Vector k is driven on cycles N+1+k·H through N+k·H+H, where H=HOLD_CYCLES.
- led_in is sampled on the last cycle of each hold. This leaves H-1 cycles of settle time.
- err_count updates on the edge after the sample cycle.
- busy lasts exactly 8·H cycles. done rises on edge N+1+8·H, and err_count/pass are final at that same edge.
- All outputs are registered. There is no combinational path from led_in or start to any output.

## Configuration
- Macro: `SPV_FAIL_LOG_EN`.
- **Defined**: adds the `first_fail_vec` and `first_fail_valid` ports.
  - On the first mismatch of a run, `first_fail_vec` latches vec and `first_fail_valid` is set.
  - Both hold until the next start or rst. Later mismatches do not overwrite them.
  - Both clear on start.
- **Not defined**: the ports and logic are absent. Only err_count/pass report results.

## Test plan
All scenarios use HOLD_CYCLES=4 and EXPECT=8'hF8.
1. Reset, then start; led_in is modelled as S|(P&V) -> vectors 0..7 each appear for 4 cycles, busy=1 for 32 cycles, then done=1, pass=1, err_count=0.
2. led_in tied 0 -> err_count=5 and pass=0 at done. With the macro, first_fail_vec=3 and first_fail_valid=1.
3. led_in tied 1 -> err_count=3 and pass=0. With the macro, first_fail_vec=0.
4. start pulsed again at cycles 5 and 20 of a run -> no effect; done still rises exactly 32 cycles after the original start.
5. rst asserted during vector 4 -> the next cycle shows IDLE, all outputs 0. A new start runs the full 32 cycles from vector 0 with a clean err_count.
6. start asserted while in DONE after a failing run -> done and err_count clear on the next edge and the run repeats. With a correct model, it ends pass=1 and first_fail_valid=0.
